// File: rtl/measure_pkg.sv
// rtl/measure_pkg.sv - shared types and constants for strobe-based measurement blocks
package measure_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_DELAY,
    ST_SAMPLE,
    ST_RESULT
  } smp_state_e;

  // ARM gives up after this many strobe periods without a rising edge
  localparam int TMO_MULT = 2;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flip-flop synchroniser for asynchronous levels
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/stb_delay_sampler.sv
// rtl/stb_delay_sampler.sv - samples a comparator at a programmable delay after each strobe
// and returns the hit count over N strobes through a valid/ready result port.
module stb_delay_sampler
  import measure_pkg::*;
#(
  parameter int T_CNT_WIDTH   = 32,
  parameter int HIT_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     stb_i,
  input  logic                     stb_rdy_i,
  input  logic [T_CNT_WIDTH-1:0]   stb_period_i,
  input  logic [T_CNT_WIDTH-1:0]   delay_i,
  input  logic [HIT_CNT_WIDTH-1:0] n_samples_i,
  input  logic                     start_i,
  input  logic                     cmp_i,
  output logic                     busy_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [HIT_CNT_WIDTH-1:0] hits_o,
  output logic                     err_o
);

  smp_state_e state_q, state_d;

  logic                     cmp_s;
  logic                     stb_q;
  logic                     stb_rise;
  logic [T_CNT_WIDTH-1:0]   delay_q, period_q, dly_cnt, to_cnt, tmo_lim;
  logic [T_CNT_WIDTH:0]     tmo_wide;
  logic [HIT_CNT_WIDTH-1:0] nsamp_q, samples_q, hits_q;
  logic                     err_q;
  logic                     start_bad, tmo_hit, last_sample;

  sync_ff #(.WIDTH(1), .STAGES(2)) u_cmp_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (cmp_i),
    .q_o    (cmp_s)
  );

  assign stb_rise    = stb_i & ~stb_q;
  assign start_bad   = !stb_rdy_i || (n_samples_i == '0) || (delay_i >= stb_period_i);
  // Limit is computed one bit wider so a huge period clips to all-ones instead of wrapping
  assign tmo_wide    = {1'b0, period_q} * (T_CNT_WIDTH+1)'(TMO_MULT);
  assign tmo_lim     = tmo_wide[T_CNT_WIDTH] ? '1 : tmo_wide[T_CNT_WIDTH-1:0];
  assign tmo_hit     = (to_cnt == tmo_lim);
  assign last_sample = ((samples_q + 1'b1) == nsamp_q);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = start_bad ? ST_RESULT : ST_ARM;
      ST_ARM:    if (stb_rise) state_d = ST_DELAY;
                 else if (tmo_hit) state_d = ST_RESULT;
      ST_DELAY:  if (dly_cnt == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_sample ? ST_RESULT : ST_ARM;
      ST_RESULT: if (res_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == ST_ARM) || (state_q == ST_DELAY) || (state_q == ST_SAMPLE);
    res_valid_o = (state_q == ST_RESULT);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      stb_q     <= 1'b0;
      delay_q   <= '0;
      period_q  <= '0;
      nsamp_q   <= '0;
      dly_cnt   <= '0;
      to_cnt    <= '0;
      samples_q <= '0;
      hits_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      stb_q <= stb_i;
      case (state_q)
        ST_IDLE: if (start_i) begin
          delay_q   <= delay_i;
          period_q  <= stb_period_i;
          nsamp_q   <= n_samples_i;
          hits_q    <= '0;
          samples_q <= '0;
          to_cnt    <= '0;
          err_q     <= start_bad;
        end
        ST_ARM: begin
          if (stb_rise)     dly_cnt <= delay_q;
          else if (tmo_hit) err_q   <= 1'b1;
          else              to_cnt  <= to_cnt + 1'b1;
        end
        ST_DELAY: if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
        ST_SAMPLE: begin
          hits_q    <= hits_q + {{(HIT_CNT_WIDTH-1){1'b0}}, cmp_s};
          samples_q <= samples_q + 1'b1;
          to_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign hits_o = hits_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_stb_delay_sampler.sv
// tb/tb_stb_delay_sampler.sv - directed self-checking bench for stb_delay_sampler
module tb_stb_delay_sampler;

  localparam int P = 100;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        stb_i = 1'b0;
  logic        stb_rdy_i = 1'b1;
  logic [31:0] stb_period_i = 32'(P);
  logic [31:0] delay_i = '0;
  logic [15:0] n_samples_i = '0;
  logic        start_i = 1'b0;
  logic        cmp_i = 1'b0;
  logic        busy_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [15:0] hits_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  int phase = 0;
  int stb_budget = -1;
  bit stb_on = 1'b0;
  bit cmp_always = 1'b0;

  stb_delay_sampler #(.T_CNT_WIDTH(32), .HIT_CNT_WIDTH(16)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .stb_i        (stb_i),
    .stb_rdy_i    (stb_rdy_i),
    .stb_period_i (stb_period_i),
    .delay_i      (delay_i),
    .n_samples_i  (n_samples_i),
    .start_i      (start_i),
    .cmp_i        (cmp_i),
    .busy_o       (busy_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .hits_o       (hits_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Strobe source: high for the first half of each period; comparator high at phase 5..59
  always @(posedge clk_i) begin
    #1;
    phase = (phase == P-1) ? 0 : phase + 1;
    if (phase == 0) begin
      if (stb_budget != 0) begin
        stb_on = 1'b1;
        if (stb_budget > 0) stb_budget--;
      end else begin
        stb_on = 1'b0;
      end
    end
    stb_i = stb_on && (phase < P/2);
    cmp_i = cmp_always || (phase >= 5 && phase < 60);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (phase != ph && k < 2*P) begin
      tick();
      k++;
    end
  endtask

  task automatic do_start(input int d, input int n);
    wait_phase(60);
    delay_i     = 32'(d);
    n_samples_i = 16'(n);
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!res_valid_o && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("res_wait", 32'(res_valid_o), 32'd1);
  endtask

  task automatic accept();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("valid_clr", 32'(res_valid_o), 32'd0);
  endtask

  task automatic run_case(input string tag, input int d, input int n, input int exp_hits);
    int cyc;
    do_start(d, n);
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    wait_result(cyc);
    chk({tag, "_hits"}, 32'(hits_o), 32'(exp_hits));
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_busy_res"}, 32'(busy_o), 32'd0);
    accept();
  endtask

  task automatic err_case(input string tag, input int d, input int n);
    do_start(d, n);
    chk({tag, "_valid"}, 32'(res_valid_o), 32'd1);
    chk({tag, "_err"}, 32'(err_o), 32'd1);
    chk({tag, "_hits"}, 32'(hits_o), 32'd0);
    accept();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dl [7] = '{70, 0, 4, 5, 59, 60, 97};
    int eh [7] = '{0, 0, 0, 8, 8, 0, 0};

    tick(); tick(); tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_hits", 32'(hits_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    arst_i = 1'b0;
    tick();

    run_case("d10", 10, 8, 8);
    for (int i = 0; i < 7; i++) run_case($sformatf("sweep%0d", dl[i]), dl[i], 8, eh[i]);

    err_case("dly_eq_period", 100, 8);
    err_case("n_zero", 10, 0);
    stb_rdy_i = 1'b0;
    err_case("not_rdy", 10, 8);
    stb_rdy_i = 1'b1;

    wait_phase(60);
    stb_budget = 3;
    cmp_always = 1'b1;
    do_start(10, 8);
    wait_result(cyc);
    chk("tmo_err", 32'(err_o), 32'd1);
    chk("tmo_hits", 32'(hits_o), 32'd3);
    chk("tmo_late", 32'(cyc >= 400), 32'd1);
    accept();
    stb_budget = -1;
    cmp_always = 1'b0;
    tick();

    do_start(10, 4);
    wait_phase(3);
    wait_phase(6);
    chk("mid_busy", 32'(busy_o), 32'd1);
    arst_i = 1'b1;
    tick(); tick();
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid", 32'(res_valid_o), 32'd0);
    chk("arst_hits", 32'(hits_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    arst_i = 1'b0;
    tick();
    run_case("post_rst", 10, 4, 4);

    do_start(10, 8);
    wait_result(cyc);
    for (int i = 0; i < 50; i++) begin
      chk("hold_valid", 32'(res_valid_o), 32'd1);
      chk("hold_hits", 32'(hits_o), 32'd8);
      chk("hold_err", 32'(err_o), 32'd0);
      chk("hold_busy", 32'(busy_o), 32'd0);
      delay_i = 32'd100;
      start_i = (i == 20);
      tick();
      start_i = 1'b0;
    end
    delay_i     = 32'd10;
    n_samples_i = 16'd8;
    start_i     = 1'b1;
    res_ready_i = 1'b1;
    tick();
    start_i     = 1'b0;
    res_ready_i = 1'b0;
    chk("hs_valid", 32'(res_valid_o), 32'd0);
    tick();
    chk("hs_start_ignored", 32'(busy_o), 32'd0);
    chk("hs_still_idle", 32'(res_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
